product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
Sequential accumulator placed directly downstream of the 8-bit multiplier. It consumes the multiplier's 16-bit unsigned products through a valid/ready handshake and sums FRAME_LENGTH consecutive products. It presents each frame sum on a registered output with its own valid/ready handshake and a per-frame overflow flag. Typical use is dot-product and MAC-style datapaths built on the combinational multiplier.

Parameters:
PRODUCT_WIDTH, 16, width of incoming product (multiplier output width)
ACC_WIDTH, 24, accumulator and result width; must be >= PRODUCT_WIDTH
FRAME_LENGTH, 8, products summed per result; must be >= 1
COUNT_WIDTH, 4, width of sample counter; must satisfy 2^COUNT_WIDTH > FRAME_LENGTH

Ports:
Clock_In  input  1  single clock, rising edge
Reset_N_In  input  1  asynchronous active-low reset
Clear_In  input  1  synchronous abort of the current partial frame
Product_In  input  PRODUCT_WIDTH  unsigned product from multiplier
Product_Valid_In  input  1  Product_In valid
Product_Ready_Out  output  1  block can accept a product this cycle
Result_Out  output  ACC_WIDTH  registered frame sum
Result_Valid_Out  output  1  Result_Out holds an unconsumed frame sum
Result_Ready_In  input  1  downstream accepts Result_Out
Overflow_Out  output  1  frame sum wrapped; qualified by Result_Valid_Out
Sample_Count_Out  output  COUNT_WIDTH  products accepted in current frame

Behaviour:
- Reset (Reset_N_In low, asynchronous):
  - Accumulator, sample count and frame-overflow bit = 0.
  - Result_Out = 0, Result_Valid_Out = 0, Overflow_Out = 0.
  - Product_Ready_Out = 1 once reset deasserts.
  - Reset mid-frame discards the partial sum and any pending result.
- States (derived, not encoded):
  - COLLECT: Result_Valid_Out = 0, or Result_Ready_In = 1.
  - STALL: Result_Valid_Out = 1 and Result_Ready_In = 0.
  - Product_Ready_Out = 1 in COLLECT, 0 in STALL. This is combinational from Result_Valid_Out and Result_Ready_In.
- Accept: a product is accepted when Product_Valid_In and Product_Ready_Out are both high at a rising edge.
- On accept, not last sample:
  - acc <= acc + zero-extended Product_In, modulo 2^ACC_WIDTH.
  - count <= count + 1.
  - frame-overflow bit |= carry out of ACC_WIDTH.
- On accept, last sample (count == FRAME_LENGTH-1):
  - Result_Out <= acc + Product_In, modulo 2^ACC_WIDTH.
  - Overflow_Out <= frame-overflow bit | carry of this add.
  - Result_Valid_Out <= 1.
  - acc, count and frame-overflow bit <= 0.
  - Latency: result is visible on the cycle after the last accept. The next frame may be accepted on that same following cycle if downstream is ready.
- Result handshake:
  - Result is consumed when Result_Valid_Out and Result_Ready_In are both high.
  - On consume with no new result loading, Result_Valid_Out <= 0.
  - On consume and last-sample accept in the same cycle, Result_Valid_Out stays 1 with the new data.
  - Result_Out and Overflow_Out are stable while Result_Valid_Out is high and not consumed.
- Clear_In (synchronous, priority over accept):
  - acc, count and frame-overflow bit <= 0.
  - A product presented that cycle is discarded, even if the handshake completes.
  - The pending result register is unaffected.
- Sample_Count_Out: registered count, range 0..FRAME_LENGTH-1.
- Product_In and Product_Valid_In are ignored when not accepted. An upstream producer must hold them stable until accepted.
- FRAME_LENGTH = 1: every accept produces a result; count remains 0.

Test Plan:
1. Default params, Result_Ready_In=1: 8 back-to-back products of 65025 (255*255) -> one cycle after 8th accept, Result_Out=0x07F008 (520200), Overflow_Out=0, Result_Valid_Out high for 1 cycle, Sample_Count_Out returns to 0.
2. ACC_WIDTH=18: same 8 x 65025 -> Result_Out=258056 (520200 mod 2^18), Overflow_Out=1. Next frame of 8 x 1 -> Result_Out=8, Overflow_Out=0.
3. Backpressure:
   - Stimulus: Result_Ready_In=0; frame of 8 x 10 completes; Result_Ready_In held low 5 cycles.
   - Required: Result_Out=80 held stable; Product_Ready_Out=0 during hold; no products accepted.
   - Then raise Result_Ready_In: result consumed; Product_Ready_Out=1 the same cycle.
4. Clear_In: 3 products of 100, then Clear_In with Product_Valid_In=1 (Product_In=500), then 8 x 1 -> Result_Out=8; the 500 is discarded; Sample_Count_Out=0 after the clear.
5. Simultaneous consume and load: Result_Ready_In=1 continuous, products valid every cycle, values 1..16 -> results 36 then 100 on consecutive frames; Result_Valid_Out pulses once per frame; no product dropped.
6. Async reset: assert Reset_N_In mid-frame (count=5) and while a result is pending -> all outputs 0 immediately, without a clock edge. After release, a fresh frame of 8 x 2 -> Result_Out=16.

Source files
------------

// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier-side producer, the accumulator and its result consumer.
// master drives products and result_ready; slave is the accumulator.
interface product_accumulator_if #(
  parameter int unsigned PRODUCT_WIDTH = 16,
  parameter int unsigned ACC_WIDTH     = 24,
  parameter int unsigned COUNT_WIDTH   = 4
);
  logic                     clear;
  logic [PRODUCT_WIDTH-1:0] product;
  logic                     product_valid;
  logic                     product_ready;
  logic [ACC_WIDTH-1:0]     result;
  logic                     result_valid;
  logic                     result_ready;
  logic                     overflow;
  logic [COUNT_WIDTH-1:0]   sample_count;

  modport master (
    output clear, product, product_valid, result_ready,
    input  product_ready, result, result_valid, overflow, sample_count
  );

  modport slave (
    input  clear, product, product_valid, result_ready,
    output product_ready, result, result_valid, overflow, sample_count
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums FRAME_LENGTH consecutive unsigned products into a registered frame result
// with a per-frame wrap flag; valid/ready on both the product and result sides.
module product_accumulator #(
  parameter int unsigned PRODUCT_WIDTH = 16,
  parameter int unsigned ACC_WIDTH     = 24,
  parameter int unsigned FRAME_LENGTH  = 8,
  parameter int unsigned COUNT_WIDTH   = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  product_accumulator_if.slave bus
);
  localparam logic [COUNT_WIDTH-1:0] LastCount = COUNT_WIDTH'(FRAME_LENGTH - 1);

  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   frame_ovf_q, frame_ovf_d;
  logic [ACC_WIDTH-1:0]   result_q, result_d;
  logic                   result_ovf_q, result_ovf_d;
  logic                   result_valid_q, result_valid_d;

  logic                   product_ready;
  logic                   accept;
  logic                   last;
  logic                   consume;
  logic [ACC_WIDTH:0]     sum;

  // Stall only while a finished result is held and downstream refuses it.
  assign product_ready = ~(result_valid_q & ~bus.result_ready);
  assign accept        = bus.product_valid & product_ready & ~bus.clear;
  assign last          = (count_q == LastCount);
  assign consume       = result_valid_q & bus.result_ready;
  // Top bit is the carry out of the accumulator width.
  assign sum           = {1'b0, acc_q} + (ACC_WIDTH + 1)'(bus.product);

  always_comb begin
    acc_d          = acc_q;
    count_d        = count_q;
    frame_ovf_d    = frame_ovf_q;
    result_d       = result_q;
    result_ovf_d   = result_ovf_q;
    result_valid_d = result_valid_q & ~consume;

    if (bus.clear) begin
      acc_d       = '0;
      count_d     = '0;
      frame_ovf_d = 1'b0;
    end else if (accept) begin
      if (last) begin
        result_d       = sum[ACC_WIDTH-1:0];
        result_ovf_d   = frame_ovf_q | sum[ACC_WIDTH];
        result_valid_d = 1'b1;
        acc_d          = '0;
        count_d        = '0;
        frame_ovf_d    = 1'b0;
      end else begin
        acc_d       = sum[ACC_WIDTH-1:0];
        count_d     = count_q + COUNT_WIDTH'(1);
        frame_ovf_d = frame_ovf_q | sum[ACC_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q          <= '0;
      count_q        <= '0;
      frame_ovf_q    <= 1'b0;
      result_q       <= '0;
      result_ovf_q   <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      acc_q          <= acc_d;
      count_q        <= count_d;
      frame_ovf_q    <= frame_ovf_d;
      result_q       <= result_d;
      result_ovf_q   <= result_ovf_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign bus.product_ready = product_ready;
  assign bus.result        = result_q;
  assign bus.result_valid  = result_valid_q;
  assign bus.overflow      = result_ovf_q;
  assign bus.sample_count  = count_q;
endmodule

// File: tb/tb_product_accumulator.sv
// Drives a 24-bit and an 18-bit accumulator with identical product streams and checks
// both against frame sums computed from the list of accepted products.
module tb_product_accumulator;
  localparam int unsigned FL = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        pv = 1'b0;
  logic        rr = 1'b0;
  logic [15:0] prod = '0;

  always #5 clk = ~clk;

  product_accumulator_if #(.PRODUCT_WIDTH(16), .ACC_WIDTH(24), .COUNT_WIDTH(4)) bus_a ();
  product_accumulator_if #(.PRODUCT_WIDTH(16), .ACC_WIDTH(18), .COUNT_WIDTH(4)) bus_b ();

  assign bus_a.clear         = clr;
  assign bus_a.product       = prod;
  assign bus_a.product_valid = pv;
  assign bus_a.result_ready  = rr;
  assign bus_b.clear         = clr;
  assign bus_b.product       = prod;
  assign bus_b.product_valid = pv;
  assign bus_b.result_ready  = rr;

  product_accumulator #(
    .PRODUCT_WIDTH(16), .ACC_WIDTH(24), .FRAME_LENGTH(FL), .COUNT_WIDTH(4)
  ) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_a)
  );

  product_accumulator #(
    .PRODUCT_WIDTH(16), .ACC_WIDTH(18), .FRAME_LENGTH(FL), .COUNT_WIDTH(4)
  ) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_b)
  );

  typedef struct {
    logic [63:0] res_a;
    bit          ovf_a;
    logic [63:0] res_b;
    bit          ovf_b;
  } exp_t;

  exp_t            sb[$];
  longint unsigned part[$];  // products accepted into the current frame
  bit              pend = 1'b0;
  bit              taken = 1'b0;
  int              tests = 0;
  int              fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t frame_expect();
    longint unsigned total = 0;
    exp_t e;
    foreach (part[i]) total += part[i];
    e.res_a = total % (64'd1 << 24);
    e.ovf_a = (total >> 24) != 0;
    e.res_b = total % (64'd1 << 18);
    e.ovf_b = (total >> 18) != 0;
    return e;
  endfunction

  // One clock of stimulus; the model advances as if the coming rising edge has happened.
  task automatic step(input bit v, input logic [15:0] p, input bit c, input bit r);
    bit exp_ready;
    bit acc;
    bit consume;
    bit load;
    @(negedge clk);
    chk("count_a", bus_a.sample_count, part.size());
    chk("count_b", bus_b.sample_count, part.size());
    chk("valid_a", bus_a.result_valid, pend);
    chk("valid_b", bus_b.result_valid, pend);
    pv = v; prod = p; clr = c; rr = r;
    #1;
    exp_ready = !(pend && !r);
    chk("ready_a", bus_a.product_ready, exp_ready);
    chk("ready_b", bus_b.product_ready, exp_ready);
    acc     = v && exp_ready && !c;
    consume = pend && r;
    load    = 1'b0;
    if (c) part.delete();
    else if (acc) begin
      part.push_back(longint'(p));
      if (part.size() == FL) begin
        sb.push_back(frame_expect());
        part.delete();
        load = 1'b1;
      end
    end
    pend  = load || (pend && !consume);
    taken = acc || c;
  endtask

  task automatic burst(input int n, input logic [15:0] p, input bit r);
    for (int i = 0; i < n; i++) step(1'b1, p, 1'b0, r);
  endtask

  task automatic async_reset();
    @(negedge clk);
    pv = 1'b0; clr = 1'b0; rr = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_result_a", bus_a.result, 0);
    chk("rst_result_b", bus_b.result, 0);
    chk("rst_valid_a", bus_a.result_valid, 0);
    chk("rst_valid_b", bus_b.result_valid, 0);
    chk("rst_ovf_a", bus_a.overflow, 0);
    chk("rst_ovf_b", bus_b.overflow, 0);
    chk("rst_count_a", bus_a.sample_count, 0);
    chk("rst_count_b", bus_b.sample_count, 0);
    chk("rst_ready_a", bus_a.product_ready, 1);
    sb.delete();
    part.delete();
    pend = 1'b0;
    @(negedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t cur;
    bit   have = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) have = 1'b0;
      else if (bus_a.result_valid) begin
        if (!have) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: got result %0d, expected no result", bus_a.result);
          end else begin
            cur  = sb.pop_front();
            have = 1'b1;
          end
        end
        if (have) begin
          chk("result_a", bus_a.result, cur.res_a);
          chk("ovf_a", bus_a.overflow, cur.ovf_a);
          chk("result_b", bus_b.result, cur.res_b);
          chk("ovf_b", bus_b.overflow, cur.ovf_b);
          if (rr) have = 1'b0;
        end
      end
    end
  end

  initial begin : driver
    bit          v;
    logic [15:0] p;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;

    // Full-scale products: 24-bit fits, 18-bit wraps.
    burst(FL, 16'd65025, 1'b1);
    burst(FL, 16'd1, 1'b1);
    step(1'b0, 16'd0, 1'b0, 1'b1);

    // Held result blocks new products until consumed.
    burst(FL, 16'd10, 1'b0);
    burst(5, 16'd7, 1'b0);
    burst(FL, 16'd7, 1'b1);

    // Clear drops the partial frame and the product offered alongside it.
    burst(3, 16'd100, 1'b1);
    step(1'b1, 16'd500, 1'b1, 1'b1);
    burst(FL, 16'd1, 1'b1);

    // Back-to-back frames with load and consume coinciding.
    for (int i = 1; i <= 16; i++) step(1'b1, 16'(i), 1'b0, 1'b1);
    step(1'b0, 16'd0, 1'b0, 1'b1);

    // Asynchronous reset mid-frame, then with a result pending.
    burst(5, 16'd4, 1'b1);
    async_reset();
    burst(FL, 16'd9, 1'b0);
    step(1'b0, 16'd0, 1'b0, 1'b0);
    async_reset();
    burst(FL, 16'd2, 1'b1);
    step(1'b0, 16'd0, 1'b0, 1'b1);

    // Random traffic; an offered product is held until it is taken.
    v = 1'b0;
    p = '0;
    taken = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (!v || taken) begin
        v = ($urandom % 4) != 0;
        p = ($urandom % 3 == 0) ? 16'hFFFF : 16'($urandom);
      end
      step(v, p, ($urandom % 25) == 0, ($urandom % 3) != 0);
    end

    repeat (4) step(1'b0, 16'd0, 1'b0, 1'b1);
    #3;
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
